t_ff_monitor: RTL and testbench

- Downstream consumer and checker for the toggle flip-flop stage; sits on the flip-flop's q/qb outputs and its t input, in the same clock domain.
- Detects q edges and counts toggles with a saturating counter.
- Checks every cycle that q and qb are complementary and that q obeys the toggle law q(n+1) = q(n) XOR t(n).
- Latches a sticky fault until cleared.

---
 rtl/t_ff_monitor.sv | 91 +++++++++
 tb/tb_t_ff_monitor.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/t_ff_monitor.sv
// Checker for a toggle flip-flop: counts q transitions, emits edge pulses, and latches a
// sticky fault when q/qb stop being complementary or q breaks the toggle law.
module t_ff_monitor #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          t_in,
    input  logic          q_in,
    input  logic          qb_in,
    input  logic          clr,
    output logic          rise_pulse,
    output logic          fall_pulse,
    output logic [CW-1:0] toggle_count,
    output logic          count_sat,
    output logic          err_compl,
    output logic          err_follow,
    output logic          fault
);

    typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

    localparam logic [CW-1:0] CntMax = '1;

    state_e state_q;
    logic   q_prev;
    logic   t_prev;

    logic q_chg;
    logic e_compl;
    logic e_follow;

    assign q_chg    = q_in ^ q_prev;
    assign e_compl  = (q_in == qb_in);
    assign e_follow = (q_in != (q_prev ^ t_prev));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q      <= StIdle;
            q_prev       <= 1'b0;
            t_prev       <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            toggle_count <= '0;
            count_sat    <= 1'b0;
            err_compl    <= 1'b0;
            err_follow   <= 1'b0;
            fault        <= 1'b0;
        end else begin
            q_prev <= q_in;
            t_prev <= t_in;
            unique case (state_q)
                StIdle: begin
                    rise_pulse <= 1'b0;
                    fall_pulse <= 1'b0;
                    state_q    <= StTrack;
                end
                StTrack: begin
                    rise_pulse <= ~q_prev & q_in;
                    fall_pulse <= q_prev & ~q_in;
                    if (q_chg && (toggle_count != CntMax)) begin
                        toggle_count <= toggle_count + CW'(1);
                    end
                    // Sticky: once at max the count never leaves it until rst/clr.
                    if ((toggle_count == CntMax) ||
                        (q_chg && (toggle_count == CntMax - CW'(1)))) begin
                        count_sat <= 1'b1;
                    end
                    if (e_compl) begin
                        err_compl <= 1'b1;
                    end
                    if (e_follow) begin
                        err_follow <= 1'b1;
                    end
                    if (e_compl || e_follow) begin
                        fault   <= 1'b1;
                        state_q <= StFault;
                    end
                end
                StFault: begin
                    rise_pulse <= 1'b0;
                    fall_pulse <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t_ff_monitor.sv
// Table-driven scoreboard bench for t_ff_monitor; runs a CW=8 and a CW=2 instance in parallel.
module tb_t_ff_monitor;

    logic clk;
    logic rst;
    logic clr;
    logic t_in;
    logic q_in;
    logic qb_in;

    logic       rise8, fall8, sat8, ec8, ef8, flt8;
    logic [7:0] cnt8;
    logic       rise2, fall2, sat2, ec2, ef2, flt2;
    logic [1:0] cnt2;

    t_ff_monitor #(.CW(8)) dut8 (
        .clk(clk), .rst(rst), .t_in(t_in), .q_in(q_in), .qb_in(qb_in), .clr(clr),
        .rise_pulse(rise8), .fall_pulse(fall8), .toggle_count(cnt8), .count_sat(sat8),
        .err_compl(ec8), .err_follow(ef8), .fault(flt8)
    );

    t_ff_monitor #(.CW(2)) dut2 (
        .clk(clk), .rst(rst), .t_in(t_in), .q_in(q_in), .qb_in(qb_in), .clr(clr),
        .rise_pulse(rise2), .fall_pulse(fall2), .toggle_count(cnt2), .count_sat(sat2),
        .err_compl(ec2), .err_follow(ef2), .fault(flt2)
    );

    typedef struct {
        logic       r, c, t, q, qb;
        logic       rise, fall;
        logic [7:0] cnt;
        logic       sat, ec, ef, flt;
        logic [1:0] cnt2;
        logic       sat2;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input bit r, c, t, q, qb, rise, fall, input int cnt,
                       input bit sat, ec, ef, flt, input int c2, input bit s2);
        vec_t v;
        v.r = r; v.c = c; v.t = t; v.q = q; v.qb = qb;
        v.rise = rise; v.fall = fall; v.cnt = cnt[7:0]; v.sat = sat;
        v.ec = ec; v.ef = ef; v.flt = flt; v.cnt2 = c2[1:0]; v.sat2 = s2;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d actual %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic add_zero(input bit r, c, t, q, qb);
        add(r, c, t, q, qb, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        vec_t e;
        rst = 1'b1; clr = 1'b0; t_in = 1'b0; q_in = 1'b0; qb_in = 1'b1;

        // Reset, then idle with a well-behaved flip-flop.
        add_zero(1, 0, 0, 0, 1);
        add_zero(1, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) add_zero(0, 0, 0, 0, 1);

        // Six toggles; last row drops t so q stays put afterwards.
        add_zero(0, 0, 1, 0, 1);
        for (int k = 1; k <= 6; k++) begin
            bit qv;
            qv = k[0];
            add(0, 0, (k < 6), qv, ~qv, qv, ~qv, k, 0, 0, 0, 0,
                (k < 3) ? k : 3, (k >= 3));
        end
        add(0, 0, 0, 0, 1, 0, 0, 6, 0, 0, 0, 0, 3, 1);

        // Complement violation, then frozen behaviour in FAULT incl. an ignored follow error.
        add(0, 0, 0, 0, 0, 0, 0, 6, 0, 1, 0, 1, 3, 1);
        add(0, 0, 1, 0, 1, 0, 0, 6, 0, 1, 0, 1, 3, 1);
        add(0, 0, 1, 1, 0, 0, 0, 6, 0, 1, 0, 1, 3, 1);
        add(0, 0, 0, 1, 0, 0, 0, 6, 0, 1, 0, 1, 3, 1);

        // clr recovery, then a follow violation that still counts its edge.
        add_zero(0, 1, 0, 0, 1);
        add_zero(0, 0, 0, 0, 1);
        add_zero(0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0);

        // clr with q=1: the IDLE cycle must not flag the jump from cleared history.
        add_zero(0, 1, 1, 1, 0);
        add_zero(0, 0, 0, 1, 0);
        add_zero(0, 0, 0, 1, 0);

        // Both errors on one edge, then rst+clr, then rst over an error condition.
        add(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0);
        add_zero(1, 1, 0, 0, 1);
        add_zero(1, 0, 0, 1, 1);
        add_zero(0, 0, 0, 0, 1);
        add_zero(0, 0, 0, 0, 1);

        // Run the 8-bit counter into saturation and one step past it.
        add_zero(0, 0, 1, 0, 1);
        for (int k = 1; k <= 256; k++) begin
            bit qv;
            qv = k[0];
            add(0, 0, (k < 256), qv, ~qv, qv, ~qv, (k < 255) ? k : 255, (k >= 255), 0, 0, 0,
                (k < 3) ? k : 3, (k >= 3));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].r; clr = vecs[i].c; t_in = vecs[i].t;
            q_in = vecs[i].q; qb_in = vecs[i].qb;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk("rise8", i, 32'(rise8), 32'(e.rise));
            chk("fall8", i, 32'(fall8), 32'(e.fall));
            chk("cnt8", i, 32'(cnt8), 32'(e.cnt));
            chk("sat8", i, 32'(sat8), 32'(e.sat));
            chk("ec8", i, 32'(ec8), 32'(e.ec));
            chk("ef8", i, 32'(ef8), 32'(e.ef));
            chk("fault8", i, 32'(flt8), 32'(e.flt));
            chk("rise2", i, 32'(rise2), 32'(e.rise));
            chk("fall2", i, 32'(fall2), 32'(e.fall));
            chk("cnt2", i, 32'(cnt2), 32'(e.cnt2));
            chk("sat2", i, 32'(sat2), 32'(e.sat2));
            chk("ec2", i, 32'(ec2), 32'(e.ec));
            chk("ef2", i, 32'(ef2), 32'(e.ef));
            chk("fault2", i, 32'(flt2), 32'(e.flt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
